scpu_shared_mem: RTL and testbench



---
 rtl/scpu_shared_mem.sv | 107 ++++++++++
 tb/tb_scpu_shared_mem.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/scpu_shared_mem.sv
// Unified single-port memory for the serial CPU: fetch and data ports arbitrated onto one array.
// Define SCPU_MEM_RR_EN for round-robin arbitration; default is fixed priority, data over fetch.
module scpu_shared_mem #(
    parameter int unsigned DW      = 8,
    parameter int unsigned AW      = 9,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned IREGION = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_dataout,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_datain,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_dataout,
    output logic          d_err
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];

    logic i_in_range;
    logic d_in_range;
    logic d_wr_ok;
    logic i_acc;
    logic d_acc;
    logic d_rd;
    logic d_wr;

    // One extra address bit keeps the compare correct when DEPTH == 2**AW.
    assign i_in_range = ({1'b0, i_addr} < (AW+1)'(DEPTH));
    assign d_in_range = ({1'b0, d_addr} < (AW+1)'(DEPTH));
    assign d_wr_ok    = d_in_range && ({1'b0, d_addr} >= (AW+1)'(IREGION));

`ifdef SCPU_MEM_RR_EN
    logic last_d;  // 1 = data port won the most recent contended cycle

    always_comb begin
        d_gnt = d_req;
        i_gnt = i_req;
        if (d_req && i_req) begin
            d_gnt = !last_d;
            i_gnt = last_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b1;
        end else if (d_req && i_req) begin
            last_d <= d_gnt;
        end
    end
`else
    assign d_gnt = d_req;
    assign i_gnt = i_req && !d_req;
`endif

    assign i_acc = i_req && i_gnt;
    assign d_acc = d_req && d_gnt;
    assign d_rd  = d_acc && !d_we;
    assign d_wr  = d_acc && d_we;

    // Storage is not reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (d_wr && d_wr_ok) begin
            mem[d_addr[IW-1:0]] <= d_datain;
        end
    end

    // Fetch read path: out-of-range fetches return zero silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rvalid  <= 1'b0;
            i_dataout <= '0;
        end else begin
            i_rvalid <= i_acc;
            if (i_acc) begin
                i_dataout <= i_in_range ? mem[i_addr[IW-1:0]] : '0;
            end
        end
    end

    // Data read path and error pulse for rejected writes or out-of-range accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_rvalid  <= 1'b0;
            d_dataout <= '0;
            d_err     <= 1'b0;
        end else begin
            d_rvalid <= d_rd;
            d_err    <= d_acc && (d_we ? !d_wr_ok : !d_in_range);
            if (d_rd) begin
                d_dataout <= d_in_range ? mem[d_addr[IW-1:0]] : '0;
            end
        end
    end

endmodule

// File: tb/tb_scpu_shared_mem.sv
// Bench for scpu_shared_mem: directed vectors plus a cycle-by-cycle behavioural model check.
module tb_scpu_shared_mem;

    localparam int unsigned DW      = 16;
    localparam int unsigned AW      = 9;
    localparam int unsigned DEPTH   = 384;
    localparam int unsigned IREGION = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_dataout;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_datain = '0;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_dataout;
    logic          d_err;

    int total = 0;
    int bad   = 0;

    scpu_shared_mem #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .IREGION(IREGION)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_dataout(i_dataout),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_datain(d_datain),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_dataout(d_dataout), .d_err(d_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: an array plus the expected registered outputs after the next edge.
    logic [DW-1:0] model_mem [DEPTH];
    logic          e_irv  = 1'b0;
    logic [DW-1:0] e_idat = '0;
    logic          e_drv  = 1'b0;
    logic [DW-1:0] e_ddat = '0;
    logic          e_derr = 1'b0;
    logic          m_last_d = 1'b1;

    always @(negedge rst_n) begin
        e_irv = 1'b0; e_idat = '0; e_drv = 1'b0; e_ddat = '0; e_derr = 1'b0;
        m_last_d = 1'b1;
    end

    // Inputs change 2 time units after posedge, so at negedge they are the ones the next edge captures.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            logic gi, gd;
            int ia, da;
            chk("m_i_rvalid", 32'(i_rvalid), 32'(e_irv));
            chk("m_i_dataout", 32'(i_dataout), 32'(e_idat));
            chk("m_d_rvalid", 32'(d_rvalid), 32'(e_drv));
            chk("m_d_dataout", 32'(d_dataout), 32'(e_ddat));
            chk("m_d_err", 32'(d_err), 32'(e_derr));
            gd = d_req;
            gi = i_req;
            if (d_req && i_req) begin
`ifdef SCPU_MEM_RR_EN
                gd = !m_last_d;
                gi = m_last_d;
                m_last_d = gd;
`else
                gi = 1'b0;
`endif
            end
            chk("m_i_gnt", 32'(i_gnt), 32'(gi));
            chk("m_d_gnt", 32'(d_gnt), 32'(gd));
            ia = int'(i_addr);
            da = int'(d_addr);
            e_irv = i_req && gi;
            if (e_irv) e_idat = (ia < DEPTH) ? model_mem[ia] : '0;
            e_drv  = d_req && gd && !d_we;
            e_derr = 1'b0;
            if (d_req && gd) begin
                if (!d_we) begin
                    e_ddat = (da < DEPTH) ? model_mem[da] : '0;
                    e_derr = (da >= DEPTH);
                end else if (da >= IREGION && da < DEPTH) begin
                    model_mem[da] = d_datain;
                end else begin
                    e_derr = 1'b1;
                end
            end
        end
    end

    task automatic step(input logic ir, input int ia, input logic dr, input logic dwe,
                        input int da, input int dd);
        @(posedge clk);
        #2;
        i_req = ir; i_addr = AW'(ia);
        d_req = dr; d_we = dwe; d_addr = AW'(da); d_datain = DW'(dd);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        logic exp_d;
        int acc;
        rst_n = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            dut.mem[i]   = DW'(i * 7 + 3);
            model_mem[i] = DW'(i * 7 + 3);
        end
        dut.mem[5]   = 16'h003C;
        model_mem[5] = 16'h003C;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_i_rvalid", 32'(i_rvalid), 32'h0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        chk("rst_i_dataout", 32'(i_dataout), 32'h0);
        chk("rst_d_dataout", 32'(d_dataout), 32'h0);
        chk("rst_d_err", 32'(d_err), 32'h0);
        rst_n = 1'b1;

        // Preload and fetch
        step(1'b1, 5, 1'b0, 1'b0, 0, 0);
        chk("fetch_gnt", 32'(i_gnt), 32'h1);
        idle();
        chk("fetch_rvalid", 32'(i_rvalid), 32'h1);
        chk("fetch_data", 32'(i_dataout), 32'h003C);

        // Protected write is rejected and leaves memory intact
        step(1'b0, 0, 1'b1, 1'b1, 10, 16'h00AB);
        idle();
        chk("prot_err", 32'(d_err), 32'h1);
        step(1'b0, 0, 1'b1, 1'b0, 10, 0);
        chk("prot_err_pulse", 32'(d_err), 32'h0);
        idle();
        chk("prot_readback", 32'(d_dataout), 32'h0049);

        // Legal write then back-to-back read of the same address
        step(1'b0, 0, 1'b1, 1'b1, 300, 16'h00AB);
        step(1'b0, 0, 1'b1, 1'b0, 300, 0);
        chk("wr300_no_err", 32'(d_err), 32'h0);
        chk("wr300_no_rvalid", 32'(d_rvalid), 32'h0);
        idle();
        chk("raw300_rvalid", 32'(d_rvalid), 32'h1);
        chk("raw300_data", 32'(d_dataout), 32'h00AB);

        // Contention: both ports request continuously
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 20, 1'b1, 1'b0, 30, 0);
`ifdef SCPU_MEM_RR_EN
            exp_d = (k % 2 == 1);
`else
            exp_d = 1'b1;
`endif
            chk("cont_d_gnt", 32'(d_gnt), 32'(exp_d));
            chk("cont_i_gnt", 32'(i_gnt), 32'(!exp_d));
        end

        // Out-of-range accesses
        step(1'b0, 0, 1'b1, 1'b0, 400, 0);
        step(1'b1, 400, 1'b0, 1'b0, 0, 0);
        chk("oor_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("oor_d_data", 32'(d_dataout), 32'h0);
        chk("oor_d_err", 32'(d_err), 32'h1);
        idle();
        chk("oor_i_rvalid", 32'(i_rvalid), 32'h1);
        chk("oor_i_data", 32'(i_dataout), 32'h0);
        chk("oor_i_no_err", 32'(d_err), 32'h0);

        // Reset pulse after an accepted read, before its edge completes the next cycle
        step(1'b0, 0, 1'b1, 1'b0, 300, 0);
        chk("rstmid_gnt", 32'(d_gnt), 32'h1);
        #1;
        rst_n = 1'b0;
        d_req = 1'b0;
        #1;
        rst_n = 1'b1;
        chk("rstmid_rvalid_now", 32'(d_rvalid), 32'h0);
        chk("rstmid_err_now", 32'(d_err), 32'h0);
        @(negedge clk);
        chk("rstmid_rvalid_next", 32'(d_rvalid), 32'h0);
        step(1'b0, 0, 1'b1, 1'b0, 300, 0);
        idle();
        chk("rstmid_mem_kept", 32'(d_dataout), 32'h00AB);

        // Loop program: running sum 25..1 stored at 258, interleaved with fetches
        acc = 0;
        for (int n = 25; n >= 1; n--) begin
            step(1'b1, n, 1'b0, 1'b0, 0, 0);
            acc += n;
            step(1'b0, 0, 1'b1, 1'b1, 258, acc);
            chk("loop_no_err", 32'(d_err), 32'h0);
        end
        step(1'b0, 0, 1'b1, 1'b0, 258, 0);
        chk("loop_store_no_err", 32'(d_err), 32'h0);
        idle();
        chk("loop_sum", 32'(d_dataout), 32'h0145);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
